// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a full-adder
// chain with one registered carry, valid/ready handshakes on both sides.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic [WIDTH-1:0] a_nx, b_nx, sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_r, ovf_r, out_valid_r, busy_r;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             last, accept;

  // One full adder per bit of the digit; c[DIGIT-1] is the carry into the MSB.
  assign c[0] = carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    serial_adder_fa u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (dsum[i]),
      .co (c[i+1])
    );
  end

  if (DIGIT == WIDTH) begin : g_single
    assign a_nx   = '0;
    assign b_nx   = '0;
    assign sum_nx = dsum;
  end else begin : g_multi
    assign a_nx   = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
    assign b_nx   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    assign sum_nx = {dsum, sum_r[WIDTH-1:DIGIT]};
  end

  assign last     = (cnt == CW'(N - 1));
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_r       <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept) begin
      // Subtract as a + ~b + 1: invert B once here, carry-in supplies the +1.
      a_sh        <= a;
      b_sh        <= b ^ {WIDTH{sub}};
      carry       <= sub;
      cnt         <= '0;
      state       <= RUN;
      busy_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh  <= a_nx;
          b_sh  <= b_nx;
          sum_r <= sum_nx;
          carry <= c[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_r      <= c[DIGIT];
            ovf_r       <= c[DIGIT-1] ^ c[DIGIT];
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder in three configurations (8/2, 4/1, 16/16),
// plus a randomized sweep against a behavioural arithmetic model.

module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a16, b16;
  logic        sb, ordy;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic        co [3];
  logic        of [3];
  logic [7:0]  s8;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [15:0] sm [3];
  int          checks = 0;
  int          errors = 0;
  int          wcfg [3] = '{8, 4, 16};
  int          ncfg [3] = '{4, 4, 1};

  always #5 clk = ~clk;

  assign sm[0] = {8'h0, s8};
  assign sm[1] = {12'h0, s4};
  assign sm[2] = s16;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a16[7:0]), .b(b16[7:0]), .sub(sb), .out_valid(ov[0]), .out_ready(ordy),
    .sum(s8), .cout(co[0]), .ovf(of[0]), .busy(bz[0]));

  serial_adder #(.WIDTH(4), .DIGIT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a16[3:0]), .b(b16[3:0]), .sub(sb), .out_valid(ov[1]), .out_ready(ordy),
    .sum(s4), .cout(co[1]), .ovf(of[1]), .busy(bz[1]));

  serial_adder #(.WIDTH(16), .DIGIT(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a16), .b(b16), .sub(sb), .out_valid(ov[2]), .out_ready(ordy),
    .sum(s16), .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic s);
    logic [31:0] m, bb, t, r;
    logic        sa, sbb, sr;
    m   = (32'd1 << w) - 32'd1;
    bb  = s ? (~{16'h0, bv}) & m : {16'h0, bv} & m;
    t   = ({16'h0, av} & m) + bb + {31'b0, s};
    r   = t & m;
    sa  = av[w-1];
    sbb = bb[w-1];
    sr  = r[w-1];
    return {(sa == sbb) && (sr != sa), t[w], r[15:0]};
  endfunction

  // One full transaction; operands are scrambled right after the accept edge.
  task automatic op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic s,
                    input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int n;
    @(negedge clk);
    a16 = av; b16 = bv; sb = s; ordy = 1'b1; iv[k] = 1'b1;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick();
    iv[k] = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sb = ~s;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ov[k] && n < 50);
    chk({tag, "_lat"},  n, ncfg[k]);
    chk({tag, "_sum"},  sm[k], es);
    chk({tag, "_cout"}, co[k], ec);
    chk({tag, "_ovf"},  of[k], eo);
    tick();
  endtask

  initial begin
    int          n, seen;
    logic [15:0] ra, rb, mk;
    logic        rs;
    logic [17:0] e;

    rst_n = 1'b0; a16 = '0; b16 = '0; sb = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir",   ir[0], 1);
    chk("rst_ov",   ov[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_sum",  sm[0], 0);
    chk("rst_flag", {co[0], of[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, "add5a3c");
    op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, "addff01");
    op(0, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0, 1'b0, "sub1020");
    op(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, "sub8001");

    // Backpressure: producer holds its next request while DONE is stalled.
    @(negedge clk);
    a16 = 16'h01; b16 = 16'h02; sb = 1'b0; iv[0] = 1'b1; ordy = 1'b0;
    tick();
    a16 = 16'h7F; b16 = 16'h01;
    n = 0;
    do begin tick(); n++; end while (!ov[0] && n < 50);
    chk("bp_lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {ov[0], ir[0], co[0], of[0], sm[0]}, {4'b1000, 16'h03});
    end
    @(negedge clk);
    ordy = 1'b1;
    #1;
    chk("bp_ir", ir[0], 1);
    tick();
    chk("bp_accept", {ov[0], bz[0]}, 2'b01);
    a16 = 16'h0F; b16 = 16'h0F; sb = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ov[0] && n < 50);
    chk("bp2_lat", n, 4);
    chk("bp2_res", {co[0], of[0], sm[0]}, {2'b01, 16'h80});
    n = 0;
    do begin tick(); n++; end while (!ov[0] && n < 50);
    iv[0] = 1'b0;
    chk("b2b_gap", n, 5);
    chk("b2b_res", {co[0], of[0], sm[0]}, {2'b10, 16'h00});
    tick();

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    a16 = 16'h32; b16 = 16'h11; sb = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ir",   ir[0], 1);
    chk("arst_ov",   ov[0], 0);
    chk("arst_busy", bz[0], 0);
    chk("arst_sum",  sm[0], 0);
    chk("arst_flag", {co[0], of[0]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0]) seen++;
    end
    chk("arst_noout", seen, 0);
    op(0, 16'h32, 16'h11, 1'b0, 16'h43, 1'b0, 1'b0, "post_rst");

    op(1, 16'h3, 16'h5, 1'b0, 16'h8, 1'b0, 1'b1, "w4_3p5");
    op(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_ffff");

    for (int k = 0; k < 3; k++) begin
      mk = 16'((32'd1 << wcfg[k]) - 32'd1);
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom) & mk;
        rb = 16'($urandom) & mk;
        rs = 1'($urandom);
        e  = model(wcfg[k], ra, rb, rs);
        op(k, ra, rb, rs, e[15:0], e[16], e[17], $sformatf("rnd%0d", k));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
